// File: rtl/drops_sequencer.sv
// drops_sequencer: per-frame phase scheduler for the drops game pipeline.
// Optional single-step mode is enabled by defining DROPS_SEQ_SINGLE_STEP_EN.
module drops_sequencer #(
    parameter int NPH       = 3,
    parameter int TO_W      = 8,
    parameter int TIMEOUT   = 200,
    parameter int FRAME_DIV = 16,
    parameter int FC_W      = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            pause_i,
    input  logic            clr_err_i,
`ifdef DROPS_SEQ_SINGLE_STEP_EN
    input  logic            step_i,
`endif
    input  logic [NPH-1:0]  done_i,
    output logic [NPH-1:0]  en_o,
    output logic [1:0]      phase_o,
    output logic            busy_o,
    output logic [FC_W-1:0] frame_o,
    output logic            overrun_o,
    output logic            timeout_o,
    output logic [1:0]      to_phase_o
);

    localparam int FD_W = (FRAME_DIV > 2) ? $clog2(FRAME_DIV) : 1;

    typedef enum logic [1:0] {IDLE, ENABLE, WAIT} state_t;

    state_t          state;
    logic [FD_W-1:0] fdiv;
    logic [TO_W-1:0] wdog;
    logic [1:0]      k;
    logic            pending;

    logic            tick;
    logic            start_pend;
    logic            start_step;
    logic            start;
    logic [NPH-1:0]  cur_sel;
    logic [NPH-1:0]  next_sel;
    logic            done_hit;
    logic            wd_expire;
    logic            last_phase;

    always_comb begin
        tick       = (fdiv == FD_W'(FRAME_DIV - 1));
        start_pend = (state == IDLE) && pending && !pause_i;
`ifdef DROPS_SEQ_SINGLE_STEP_EN
        start_step = (state == IDLE) && pause_i && step_i;
`else
        start_step = 1'b0;
`endif
        start      = start_pend || start_step;
        cur_sel    = NPH'(1) << k;
        next_sel   = NPH'(1) << (k + 2'd1);
        done_hit   = (done_i & cur_sel) != '0;
        wd_expire  = (wdog == TO_W'(TIMEOUT - 1));
        last_phase = (k == 2'(NPH - 1));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            fdiv <= '0;
        end else if (tick) begin
            fdiv <= '0;
        end else begin
            fdiv <= fdiv + FD_W'(1);
        end
    end

    // Ticks do not queue: a second tick while one is pending only flags overrun.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending   <= 1'b0;
            overrun_o <= 1'b0;
        end else begin
            overrun_o <= tick && pending && !start_pend;
            if (tick) begin
                pending <= 1'b1;
            end else if (start_pend) begin
                pending <= 1'b0;
            end
        end
    end

    // Enable is raised on entry to ENABLE so each phase shows it for ENABLE plus WAIT.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state      <= IDLE;
            k          <= 2'd0;
            wdog       <= '0;
            en_o       <= '0;
            phase_o    <= 2'd0;
            busy_o     <= 1'b0;
            frame_o    <= '0;
            timeout_o  <= 1'b0;
            to_phase_o <= 2'd0;
        end else begin
            if (clr_err_i) begin
                timeout_o  <= 1'b0;
                to_phase_o <= 2'd0;
            end
            case (state)
                IDLE: begin
                    busy_o <= 1'b0;
                    if (start) begin
                        k       <= 2'd0;
                        en_o    <= NPH'(1);
                        phase_o <= 2'd0;
                        busy_o  <= 1'b1;
                        state   <= ENABLE;
                    end
                end
                ENABLE: begin
                    en_o    <= cur_sel;
                    phase_o <= k;
                    wdog    <= '0;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (done_hit || wd_expire) begin
                        if (!done_hit) begin
                            timeout_o  <= 1'b1;
                            to_phase_o <= k;
                        end
                        if (last_phase) begin
                            en_o    <= '0;
                            frame_o <= frame_o + FC_W'(1);
                            busy_o  <= 1'b0;
                            state   <= IDLE;
                        end else begin
                            k       <= k + 2'd1;
                            en_o    <= next_sel;
                            phase_o <= k + 2'd1;
                            state   <= ENABLE;
                        end
                    end else begin
                        wdog <= wdog + TO_W'(1);
                    end
                end
                default: begin
                    en_o   <= '0;
                    busy_o <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drops_sequencer.sv
// Scoreboard bench for drops_sequencer: expected frames are queued by the
// stimulus thread and checked by a monitor whenever a frame completes.
module tb_drops_sequencer;

    typedef struct {
        int frame;
        int c0;
        int c1;
        int c2;
        int order;
        int to;
        int tp;
    } exp_t;

    localparam int NORMAL_ORDER = 9'b100_010_001;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pause;
    logic       clr_err;
    logic [2:0] done;
`ifdef DROPS_SEQ_SINGLE_STEP_EN
    logic       step;
`endif
    logic [2:0] en;
    logic [1:0] phase;
    logic       busy;
    logic [7:0] frame;
    logic       overrun;
    logic       timeout;
    logic [1:0] to_phase;

    int   n_checks = 0;
    int   n_fail   = 0;
    int   frames_done = 0;
    int   exp_frame = 0;
    exp_t exp_q[$];

    int         cnt[3];
    logic [8:0] trace;
    int         ntr;
    int         stray;
    logic       prev_busy;
    logic [2:0] prev_en;

    drops_sequencer dut (
        .clk_i      (clk),
        .rst_n_i    (rst_n),
        .pause_i    (pause),
        .clr_err_i  (clr_err),
`ifdef DROPS_SEQ_SINGLE_STEP_EN
        .step_i     (step),
`endif
        .done_i     (done),
        .en_o       (en),
        .phase_o    (phase),
        .busy_o     (busy),
        .frame_o    (frame),
        .overrun_o  (overrun),
        .timeout_o  (timeout),
        .to_phase_o (to_phase)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [2:0] d, input logic p, input logic c);
        done    = d;
        pause   = p;
        clr_err = c;
    endtask

    task automatic pushFrame(input int c0, input int c1, input int c2, input int to, input int tp);
        exp_t e;
        exp_frame++;
        e.frame = exp_frame % 256;
        e.c0 = c0;
        e.c1 = c1;
        e.c2 = c2;
        e.order = NORMAL_ORDER;
        e.to = to;
        e.tp = tp;
        exp_q.push_back(e);
    endtask

    task automatic waitFrames(input int target, input int budget);
        int n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checkOutput("frame_wait", frames_done, target);
    endtask

    task automatic waitEn(input logic [2:0] target);
        int n = 0;
        while (en != target && n < 100) begin
            @(negedge clk);
            n++;
        end
        checkOutput("wait_en", int'(en), int'(target));
    endtask

    task automatic checkStartLatency(input int expected);
        int lat = 0;
        while (!busy && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        checkOutput("start_latency", lat, expected);
    endtask

    // Monitor: captures per-phase enable lengths and phase order, then scores each frame.
    always @(negedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 3; i++) cnt[i] = 0;
            trace = '0;
            ntr = 0;
            stray = 0;
            prev_busy = 1'b0;
            prev_en = '0;
        end else if (busy) begin
            for (int i = 0; i < 3; i++) if (en[i]) cnt[i]++;
            if (en != '0 && en != prev_en && ntr < 3) begin
                trace = trace | (9'(en) << (3 * ntr));
                ntr++;
            end
            prev_en = en;
            prev_busy = 1'b1;
        end else begin
            if (en != '0) stray++;
            if (prev_busy) begin
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_frame", 1, 0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    checkOutput("frame_count", int'(frame), e.frame);
                    checkOutput("en0_cycles", cnt[0], e.c0);
                    checkOutput("en1_cycles", cnt[1], e.c1);
                    checkOutput("en2_cycles", cnt[2], e.c2);
                    checkOutput("phase_order", int'(trace), e.order);
                    checkOutput("timeout_flag", int'(timeout), e.to);
                    checkOutput("to_phase", int'(to_phase), e.tp);
                    checkOutput("last_phase", int'(phase), 2);
                    checkOutput("idle_enable", stray, 0);
                end
                frames_done++;
                stray = 0;
            end
            for (int i = 0; i < 3; i++) cnt[i] = 0;
            trace = '0;
            ntr = 0;
            prev_en = '0;
            prev_busy = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] simulation time limit");
    end

    initial begin
        int ov;
        int busy_cycles;
        int base;
        rst_n = 1'b0;
`ifdef DROPS_SEQ_SINGLE_STEP_EN
        step = 1'b0;
`endif
        applyStimulus(3'b111, 1'b0, 1'b0);
        #12;
        checkOutput("rst_en", int'(en), 0);
        checkOutput("rst_phase", int'(phase), 0);
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_frame", int'(frame), 0);
        checkOutput("rst_overrun", int'(overrun), 0);
        checkOutput("rst_timeout", int'(timeout), 0);
        checkOutput("rst_to_phase", int'(to_phase), 0);

        @(negedge clk);
        rst_n = 1'b1;
        pushFrame(2, 2, 2, 0, 0);
        checkStartLatency(17);
        waitFrames(1, 100);

        $display("[TB] normal frames");
        pushFrame(2, 2, 2, 0, 0);
        pushFrame(2, 2, 2, 0, 0);
        waitFrames(3, 100);

        $display("[TB] phase isolation");
        applyStimulus(3'b000, 1'b0, 1'b0);
        pushFrame(7, 2, 2, 0, 0);
        waitEn(3'b001);
        applyStimulus(3'b100, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("iso_en_during_pulse", int'(en), 1);
        applyStimulus(3'b000, 1'b0, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("iso_en_held", int'(en), 1);
        applyStimulus(3'b111, 1'b0, 1'b0);
        waitFrames(4, 100);

        $display("[TB] pause");
        applyStimulus(3'b111, 1'b1, 1'b0);
        ov = 0;
        busy_cycles = 0;
        repeat (48) begin
            @(negedge clk);
            if (overrun) ov++;
            if (busy) busy_cycles++;
        end
        checkOutput("pause_overruns", ov, 2);
        checkOutput("pause_busy", busy_cycles, 0);
        pushFrame(2, 2, 2, 0, 0);
        applyStimulus(3'b111, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("unpause_start", int'(busy), 1);
        waitFrames(5, 100);

        $display("[TB] watchdog");
        applyStimulus(3'b101, 1'b0, 1'b0);
        pushFrame(2, 201, 2, 1, 1);
        waitFrames(6, 400);
        applyStimulus(3'b111, 1'b0, 1'b0);
        pushFrame(2, 2, 2, 1, 1);
        waitFrames(7, 100);
        applyStimulus(3'b111, 1'b0, 1'b1);
        @(negedge clk);
        applyStimulus(3'b111, 1'b0, 1'b0);
        checkOutput("clr_timeout", int'(timeout), 0);
        checkOutput("clr_to_phase", int'(to_phase), 0);

        $display("[TB] async reset");
        waitEn(3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("arst_en", int'(en), 0);
        checkOutput("arst_busy", int'(busy), 0);
        @(negedge clk);
        checkOutput("arst_frame", int'(frame), 0);
        checkOutput("arst_phase", int'(phase), 0);
        checkOutput("arst_timeout", int'(timeout), 0);
        checkOutput("arst_overrun", int'(overrun), 0);
        exp_frame = 0;
        @(negedge clk);
        rst_n = 1'b1;
        pushFrame(2, 2, 2, 0, 0);
        checkStartLatency(17);

        $display("[TB] frame counter wrap");
        base = frames_done;
        for (int i = 0; i < 255; i++) pushFrame(2, 2, 2, 0, 0);
        waitFrames(base + 256, 5000);
        checkOutput("wrap_frame", int'(frame), 0);

`ifdef DROPS_SEQ_SINGLE_STEP_EN
        $display("[TB] single step");
        applyStimulus(3'b111, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        checkOutput("step_idle", int'(busy), 0);
        base = frames_done;
        pushFrame(2, 2, 2, 0, 0);
        step = 1'b1;
        @(negedge clk);
        step = 1'b0;
        waitFrames(base + 1, 100);
        repeat (40) @(negedge clk);
        checkOutput("step_one_frame", frames_done, base + 1);
        checkOutput("step_frame", int'(frame), 1);
`endif

        checkOutput("queue_empty", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/drops_sequencer.md
Name: drops_sequencer

Overview:
- Central phase scheduler for the drops game pipeline.
- Drives the enable/done handshakes of the input, action and display stages in fixed order (phase 0, then 1, then 2) once per frame.
- Paces frames to a minimum period, guards every phase with a watchdog timeout, and supports pause plus a sticky error flag.
- Replaces the ad-hoc top-level sequencing FSM; sits between the top-level pins and the three stage blocks.

Parameters:
- NPH, 3, number of sequenced phases (1..4); phase k maps to en_o[k]/done_i[k].
- TO_W, 8, watchdog counter width.
- TIMEOUT, 200, maximum WAIT cycles per phase before forced abort (1..2^TO_W-1).
- FRAME_DIV, 16, frame tick period in clk_i cycles (>=2).
- FC_W, 8, frame counter width.

Ports:
- clk_i  in  1  clock; all logic on rising edge.
- rst_n_i  in  1  asynchronous active-low reset.
- pause_i  in  1  level; while high, no new frame starts.
- clr_err_i  in  1  synchronous pulse; clears timeout_o and to_phase_o.
- done_i  in  NPH  per-phase done level from stage blocks.
- en_o  out  NPH  per-phase enable, at most one bit high (one-hot or zero).
- phase_o  out  2  index of the current/last active phase.
- busy_o  out  1  high while a frame is in progress.
- frame_o  out  FC_W  completed-frame count, wraps modulo 2^FC_W.
- overrun_o  out  1  one-cycle pulse: frame tick arrived while a tick was already pending.
- timeout_o  out  1  sticky watchdog error flag.
- to_phase_o  out  2  phase that last timed out.

Behaviour:
- Reset values: en_o=0, phase_o=0, busy_o=0, frame_o=0, overrun_o=0, timeout_o=0, to_phase_o=0. Internal state: FSM=IDLE, fdiv=0, wdog=0, pending=0.
- Frame divider: fdiv free-runs 0..FRAME_DIV-1 and wraps; tick fires when fdiv==FRAME_DIV-1.
- Tick handling: a tick sets pending. A tick that arrives while pending=1 pulses overrun_o for one cycle; pending stays 1 (ticks do not queue).
- FSM states: IDLE, ENABLE, WAIT.
- IDLE:
  - busy_o=0.
  - If pending=1 and pause_i=0: clear pending, set k=0, busy_o<=1, go to ENABLE.
- ENABLE:
  - en_o[k]<=1, phase_o<=k, wdog<=0, go to WAIT.
  - done_i is ignored in this state, so a stale done from the previous activation is rejected.
- WAIT, sampled every cycle:
  - done_i[k]=1: en_o[k]<=0. If k<NPH-1: k<=k+1, go to ENABLE. Else: frame_o<=frame_o+1, busy_o<=0, go to IDLE.
  - Else if wdog==TIMEOUT-1: en_o[k]<=0, timeout_o<=1, to_phase_o<=k, then advance exactly as if done.
  - Else: wdog<=wdog+1.
- Timing: each phase costs 1 ENABLE cycle plus 1 or more WAIT cycles; the minimum frame is 2*NPH cycles. With done_i already high at first WAIT sample, en_o[k] is high for exactly 2 cycles.
- Phase isolation: done_i bits of non-active phases are ignored in every state.
- pause_i is sampled in IDLE only; a frame already in progress always completes.
- clr_err_i and a timeout in the same cycle: the timeout wins (flag stays 1).
- Asynchronous reset mid-frame immediately drops en_o to 0 and returns all state to reset values.
- frame_o wraps from 2^FC_W-1 to 0 with no flag.

Optional Feature:
- Macro: DROPS_SEQ_SINGLE_STEP_EN.
- Defined:
  - Adds input step_i (1 bit).
  - While pause_i=1, a step_i pulse in IDLE starts exactly one frame regardless of pending; pending is left unchanged.
  - step_i is ignored when pause_i=0 or when not in IDLE.
- Undefined: no step_i port; pause_i simply holds the FSM in IDLE.

Test Plan:
- Reset, then FRAME_DIV=16, done_i tied to 3'b111 -> en_o pattern 001,001,010,010,100,100, then 000. frame_o=1 after first frame; busy_o high for 6 cycles.
- done_i[1] held 0, TIMEOUT=200 -> en_o[1] high for 201 cycles, then timeout_o=1, to_phase_o=1, phase 2 runs; clr_err_i pulse -> timeout_o=0.
- pause_i=1 before a tick -> busy_o stays 0 across 3 ticks with overrun_o pulses on ticks 2 and 3. Release pause_i -> exactly one frame starts next cycle.
- done_i[2] pulsed while phase 0 active -> ignored; en_o stays 001 until done_i[0].
- Async reset asserted while en_o=010 -> en_o=000 without waiting for a clock edge. After release, first frame begins 16 cycles later; frame_o=0.
- 256 frames completed with FC_W=8 -> frame_o wraps to 0. With DROPS_SEQ_SINGLE_STEP_EN defined, pause_i=1 and one step_i pulse -> exactly one frame runs, frame_o increments by 1.
